// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA master, the arbiter and DataMemory.
// The arbiter sits on the slave side. The pipeline, DMA engine and memory
// model together form the master side.
interface dmem_arbiter_if;
    // CPU MEM-stage port
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    // DMA burst port
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [3:0]  dma_len;
    logic [31:0] dma_wdata;
    logic        dma_beat;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        dma_done;
    logic        dma_busy;

    // DataMemory port
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        output dma_beat, dma_rdata, dma_rvalid, dma_done, dma_busy,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        input  dma_beat, dma_rdata, dma_rvalid, dma_done, dma_busy,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU MEM stage has priority over a burst DMA master.
// A wait counter forces one DMA slot after MAX_WAIT denied cycles. In that
// slot the CPU request is stalled and replayed on the following cycle.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic           sysclk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        we_reg, we_next;
    logic [31:0] burst_addr_reg, burst_addr_next;
    logic [3:0]  len_reg, len_next;
    logic [3:0]  beat_cnt_reg, beat_cnt_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic [31:0] dma_rdata_reg, dma_rdata_next;
    logic        dma_rvalid_reg, dma_rvalid_next;

    logic        cpu_req;
    logic        dma_win;

    // Zero-latency grant: DMA wins when the CPU is quiet or has starved it long enough
    always_comb begin
        cpu_req = bus.cpu_read | bus.cpu_write;
        dma_win = (state_reg == BURST) && (!cpu_req || (wait_cnt_reg == MAX_WAIT_L));
    end

    // Memory mux and handshake outputs; a stalled CPU access is replayed next cycle
    always_comb begin
        bus.cpu_stall  = cpu_req & dma_win;
        bus.dma_beat   = dma_win;
        bus.cpu_rdata  = bus.mem_rdata;
        bus.dma_rdata  = dma_rdata_reg;
        bus.dma_rvalid = dma_rvalid_reg;
        bus.dma_done   = (state_reg == DONE);
        bus.dma_busy   = (state_reg != IDLE);
        if (dma_win) begin
            bus.mem_addr  = burst_addr_reg;
            bus.mem_wdata = bus.dma_wdata;
            bus.mem_write = we_reg;
            bus.mem_read  = !we_reg;
        end else begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_write = bus.cpu_write;
            bus.mem_read  = bus.cpu_read;
        end
    end

    // Next-state logic for the burst FSM, beat/wait counters and DMA read capture
    always_comb begin
        state_next      = state_reg;
        we_next         = we_reg;
        burst_addr_next = burst_addr_reg;
        len_next        = len_reg;
        beat_cnt_next   = beat_cnt_reg;
        wait_cnt_next   = 4'd0;
        dma_rdata_next  = dma_rdata_reg;
        dma_rvalid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.dma_req) begin
                    // Word-align the start address; the low two bits are dropped
                    we_next         = bus.dma_we;
                    burst_addr_next = bus.dma_addr & ~32'd3;
                    len_next        = bus.dma_len;
                    beat_cnt_next   = 4'd0;
                    state_next      = BURST;
                end
            end
            BURST: begin
                if (dma_win) begin
                    // Address wraps naturally modulo 2^32
                    burst_addr_next = burst_addr_reg + 32'd4;
                    beat_cnt_next   = beat_cnt_reg + 4'd1;
                    if (!we_reg) begin
                        dma_rdata_next  = bus.mem_rdata;
                        dma_rvalid_next = 1'b1;
                    end
                    if (beat_cnt_reg == len_reg) begin
                        state_next = DONE;
                    end
                end else begin
                    // Only reached while wait_cnt < MAX_WAIT, so it saturates at MAX_WAIT
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            DONE: begin
                // dma_req is deliberately ignored here
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any burst without reporting completion
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            burst_addr_reg <= 32'd0;
            len_reg        <= 4'd0;
            beat_cnt_reg   <= 4'd0;
            wait_cnt_reg   <= 4'd0;
            dma_rdata_reg  <= 32'd0;
            dma_rvalid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            we_reg         <= we_next;
            burst_addr_reg <= burst_addr_next;
            len_reg        <= len_next;
            beat_cnt_reg   <= beat_cnt_next;
            wait_cnt_reg   <= wait_cnt_next;
            dma_rdata_reg  <= dma_rdata_next;
            dma_rvalid_reg <= dma_rvalid_next;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small behavioural DataMemory.
module tb_dmem_arbiter;

    logic sysclk;
    logic reset;
    int   n_cmp;
    int   n_err;

    dmem_arbiter_if bus();

    dmem_arbiter #(.MAX_WAIT(3)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    // 256-word memory indexed by addr[9:2]: combinational read, clocked write
    logic [31:0] mem [0:255];
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    always @(posedge sysclk) begin
        if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge sysclk);
        #1;
    endtask

    task automatic sample;
        @(negedge sysclk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);

        reset         = 1'b1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = 32'd0;
        bus.cpu_wdata = 32'd0;
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = 32'd0;
        bus.dma_len   = 4'd0;
        bus.dma_wdata = 32'd0;

        // Reset state
        sample;
        check("rst busy",   32'(bus.dma_busy),   32'd0);
        check("rst done",   32'(bus.dma_done),   32'd0);
        check("rst rvalid", 32'(bus.dma_rvalid), 32'd0);
        check("rst rdata",  bus.dma_rdata,       32'd0);
        check("rst beat",   32'(bus.dma_beat),   32'd0);
        check("rst stall",  32'(bus.cpu_stall),  32'd0);
        next_cycle;
        reset = 1'b0;
        $display("reset released");

        // 1: idle CPU, 4-word write burst at 0x100
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h100;
        bus.dma_len = 4'd3; bus.dma_wdata = 32'hA0;
        sample;
        check("t1 c0 beat", 32'(bus.dma_beat), 32'd0);
        next_cycle;
        bus.dma_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.dma_wdata = 32'hA0 + 32'(i);
            sample;
            check("t1 beat",  32'(bus.dma_beat),  32'd1);
            check("t1 addr",  bus.mem_addr,       32'h100 + 32'(4 * i));
            check("t1 wr",    32'(bus.mem_write), 32'd1);
            check("t1 wdata", bus.mem_wdata,      32'hA0 + 32'(i));
            check("t1 stall", 32'(bus.cpu_stall), 32'd0);
            next_cycle;
        end
        sample;
        check("t1 done",  32'(bus.dma_done), 32'd1);
        check("t1 busy",  32'(bus.dma_busy), 32'd1);
        check("t1 beat5", 32'(bus.dma_beat), 32'd0);
        check("t1 mem10c", mem[8'h43], 32'hA3);
        check("t1 mem100", mem[8'h40], 32'hA0);
        next_cycle;
        sample;
        check("t1 done off", 32'(bus.dma_done), 32'd0);
        check("t1 busy off", 32'(bus.dma_busy), 32'd0);
        next_cycle;
        $display("burst write 0x100 len 3 complete");

        // 2: continuous CPU loads, 2-word DMA read from 0x200
        bus.cpu_read = 1'b1; bus.cpu_addr = 32'h40;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h200; bus.dma_len = 4'd1;
        sample;
        check("t2 c0 stall", 32'(bus.cpu_stall), 32'd0);
        next_cycle;
        bus.dma_req = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            sample;
            check("t2 stall",  32'(bus.cpu_stall),  (c == 4 || c == 8) ? 32'd1 : 32'd0);
            check("t2 beat",   32'(bus.dma_beat),   (c == 4 || c == 8) ? 32'd1 : 32'd0);
            check("t2 rvalid", 32'(bus.dma_rvalid), (c == 5 || c == 9) ? 32'd1 : 32'd0);
            if (c == 4) check("t2 addr b0", bus.mem_addr, 32'h200);
            else if (c == 8) check("t2 addr b1", bus.mem_addr, 32'h204);
            else begin
                check("t2 cpu addr",  bus.mem_addr,  32'h40);
                check("t2 cpu rdata", bus.cpu_rdata, 32'hA5A5_0010);
            end
            if (c == 5) check("t2 rdata0", bus.dma_rdata, 32'hA5A5_0080);
            if (c == 9) begin
                check("t2 rdata1", bus.dma_rdata,       32'hA5A5_0081);
                check("t2 done",   32'(bus.dma_done),   32'd1);
            end
            next_cycle;
        end
        bus.cpu_read = 1'b0;
        sample;
        check("t2 busy off", 32'(bus.dma_busy), 32'd0);
        next_cycle;
        $display("burst read 0x200 len 1 under cpu load complete");

        // 3: CPU store and forced DMA write to the same word
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h20; bus.dma_len = 4'd0;
        bus.dma_wdata = 32'hDDDD_0000;
        bus.cpu_read = 1'b1; bus.cpu_addr = 32'h0;
        sample;
        next_cycle;
        bus.dma_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            sample;
            check("t3 denied", 32'(bus.dma_beat), 32'd0);
            next_cycle;
        end
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b1;
        bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'hCCCC_0000;
        sample;
        check("t3 stall",  32'(bus.cpu_stall), 32'd1);
        check("t3 wr",     32'(bus.mem_write), 32'd1);
        check("t3 dwdata", bus.mem_wdata,      32'hDDDD_0000);
        next_cycle;
        sample;
        check("t3 dma first", mem[8'h08],         32'hDDDD_0000);
        check("t3 stall off", 32'(bus.cpu_stall), 32'd0);
        check("t3 cwdata",    bus.mem_wdata,      32'hCCCC_0000);
        check("t3 done",      32'(bus.dma_done),  32'd1);
        next_cycle;
        bus.cpu_write = 1'b0;
        sample;
        check("t3 cpu last", mem[8'h08], 32'hCCCC_0000);
        next_cycle;
        $display("store collision at 0x20 resolved");

        // 4: reset during the 2nd beat of a 16-word burst
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h300;
        bus.dma_len = 4'd15; bus.dma_wdata = 32'h77;
        sample;
        next_cycle;
        bus.dma_req = 1'b0;
        sample;
        check("t4 b0 addr", bus.mem_addr, 32'h300);
        next_cycle;
        sample;
        check("t4 b1 beat", 32'(bus.dma_beat), 32'd1);
        check("t4 b1 addr", bus.mem_addr,      32'h304);
        reset = 1'b1;
        #1;
        check("t4 r beat",   32'(bus.dma_beat),   32'd0);
        check("t4 r stall",  32'(bus.cpu_stall),  32'd0);
        check("t4 r busy",   32'(bus.dma_busy),   32'd0);
        check("t4 r done",   32'(bus.dma_done),   32'd0);
        check("t4 r rvalid", 32'(bus.dma_rvalid), 32'd0);
        check("t4 r rdata",  bus.dma_rdata,       32'd0);
        check("t4 r wr",     32'(bus.mem_write),  32'd0);
        next_cycle;
        sample;
        check("t4 held done", 32'(bus.dma_done), 32'd0);
        next_cycle;
        reset = 1'b0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h180; bus.dma_len = 4'd0;
        sample;
        check("t4 idle busy", 32'(bus.dma_busy), 32'd0);
        next_cycle;
        bus.dma_req = 1'b0;
        sample;
        check("t4 new beat", 32'(bus.dma_beat), 32'd1);
        check("t4 new addr", bus.mem_addr,      32'h180);
        check("t4 new rd",   32'(bus.mem_read), 32'd1);
        next_cycle;
        sample;
        check("t4 new rvalid", 32'(bus.dma_rvalid), 32'd1);
        check("t4 new rdata",  bus.dma_rdata,       32'hA5A5_0060);
        check("t4 new done",   32'(bus.dma_done),   32'd1);
        next_cycle;
        $display("reset mid-burst and restart at 0x180 complete");

        // 5: address wrap, dma_req in DONE ignored, unaligned restart
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'hFFFF_FFF8; bus.dma_len = 4'd2;
        sample;
        next_cycle;
        bus.dma_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample;
            check("t5 beat", 32'(bus.dma_beat), 32'd1);
            check("t5 addr", bus.mem_addr,      32'hFFFF_FFF8 + 32'(4 * i));
            next_cycle;
        end
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h103;
        bus.dma_len = 4'd0; bus.dma_wdata = 32'hE0E0;
        sample;
        check("t5 done",   32'(bus.dma_done),   32'd1);
        check("t5 busy",   32'(bus.dma_busy),   32'd1);
        check("t5 rvalid", 32'(bus.dma_rvalid), 32'd1);
        check("t5 rdata",  bus.dma_rdata,       32'hA5A5_0000);
        next_cycle;
        sample;
        check("t5 busy off", 32'(bus.dma_busy), 32'd0);
        check("t5 no beat",  32'(bus.dma_beat), 32'd0);
        next_cycle;
        sample;
        check("t5 re beat", 32'(bus.dma_beat),  32'd1);
        check("t5 aligned", bus.mem_addr,       32'h100);
        check("t5 re wr",   32'(bus.mem_write), 32'd1);
        next_cycle;
        bus.dma_req = 1'b0;
        sample;
        check("t5 re done", 32'(bus.dma_done), 32'd1);
        check("t5 re mem",  mem[8'h40],        32'hE0E0);
        next_cycle;
        sample;
        check("t5 final busy", 32'(bus.dma_busy), 32'd0);
        $display("wrap burst and unaligned restart complete");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
